// File: rtl/a5_stream_cipher_if.sv
// A5/1 cipher bus: key/frame load, payload in/out valid-ready, debug keystream.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready/out_ready handshakes; key_ready gates the serial key.
// Ports: start/frame (session load), key_bit/key_valid/key_ready (serial key),
//        in_data/in_valid/in_ready (plaintext), out_data/out_valid/out_ready
//        (ciphertext), ks_bit/ks_valid (debug keystream), busy (status).
interface a5_stream_cipher_if #(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = 22
);
  logic               start;
  logic [FRAME_W-1:0] frame;
  logic               key_bit;
  logic               key_valid;
  logic               key_ready;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               ks_bit;
  logic               ks_valid;
  logic               busy;

  // master = key source / payload environment, slave = cipher engine
  modport master (
    output start, frame, key_bit, key_valid, in_data, in_valid, out_ready,
    input  key_ready, in_ready, out_data, out_valid, ks_bit, ks_valid, busy
  );
  modport slave (
    input  start, frame, key_bit, key_valid, in_data, in_valid, out_ready,
    output key_ready, in_ready, out_data, out_valid, ks_bit, ks_valid, busy
  );
endinterface

// File: rtl/a5_stream_cipher.sv
// A5/1 engine: serial key + parallel frame load, warm-up, then XOR words with keystream.
// Latency: word accepted in cycle T is on out_data from T+DATA_W+1 (one keystream bit/cycle).
// Backpressure: out_valid/out_data held until out_ready; in_ready = READY && (!out_valid || out_ready).
// Ports: clk, rst (async active-high), bus (a5_stream_cipher_if.slave).
module a5_stream_cipher #(
  parameter int DATA_W  = 8,
  parameter int KEY_W   = 64,
  parameter int FRAME_W = 22,
  parameter int WARMUP  = 100
) (
  input logic            clk,
  input logic            rst,
  a5_stream_cipher_if.slave bus
);

  localparam int MAX1  = (KEY_W > FRAME_W) ? KEY_W : FRAME_W;
  localparam int MAX2  = (MAX1 > WARMUP) ? MAX1 : WARMUP;
  localparam int CMAX  = (MAX2 > DATA_W) ? MAX2 : DATA_W;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CNT_W-1:0] GEN_LAST   = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_FRAME, S_MIX, S_READY, S_GEN} state_t;

  state_t             state, state_n;
  logic [18:0]        r1, r1_n;
  logic [21:0]        r2, r2_n;
  logic [22:0]        r3, r3_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [FRAME_W-1:0] frame_q, frame_n;
  logic [DATA_W-1:0]  data_q, data_n;
  logic [DATA_W-1:0]  ks_word, ks_word_n;
  logic [DATA_W-1:0]  out_data_q, out_data_n;
  logic               out_valid_q, out_valid_n;

  logic       maj, ks, inj;
  logic [2:0] step;          // {r1, r2, r3} step enables
  logic       in_ready_i, accept_word, start_ok;

  assign maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);

  assign in_ready_i  = (state == S_READY) && (!out_valid_q || bus.out_ready);
  assign accept_word = bus.in_valid && in_ready_i;
  // A word offered with in_ready high must be taken, so it wins over a rekey
  // request in the same cycle; rekey is also refused while a result is pending.
  assign start_ok = bus.start &&
                    ((state == S_IDLE) ||
                     ((state == S_READY) && !out_valid_q && !accept_word));

  always_comb begin
    step        = 3'b000;
    inj         = 1'b0;
    state_n     = state;
    cnt_n       = cnt;
    frame_n     = frame_q;
    data_n      = data_q;
    ks_word_n   = ks_word;
    out_data_n  = out_data_q;
    out_valid_n = out_valid_q;

    // Register clocking: unconditional with injected bit during load,
    // majority-controlled during warm-up and keystream generation.
    case (state)
      S_KEY: begin
        step = {3{bus.key_valid}};
        inj  = bus.key_bit;
      end
      S_FRAME: begin
        step = 3'b111;
        inj  = frame_q[0];
      end
      S_MIX, S_GEN: step = {r1[8] == maj, r2[10] == maj, r3[10] == maj};
      default: ;
    endcase

    r1_n = step[2] ? {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ inj} : r1;
    r2_n = step[1] ? {r2[20:0], r2[20] ^ r2[21] ^ inj} : r2;
    r3_n = step[0] ? {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ inj} : r3;
    if (start_ok) begin
      r1_n = '0;
      r2_n = '0;
      r3_n = '0;
    end
    // Keystream is taken from the post-step register contents.
    ks = r1_n[18] ^ r2_n[21] ^ r3_n[22];

    if (out_valid_q && bus.out_ready) out_valid_n = 1'b0;

    case (state)
      S_IDLE: ;
      S_KEY: begin
        if (bus.key_valid) begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == KEY_LAST) begin
            cnt_n   = '0;
            state_n = S_FRAME;
          end
        end
      end
      S_FRAME: begin
        frame_n = frame_q >> 1;
        cnt_n   = cnt + CNT_W'(1);
        if (cnt == FRAME_LAST) begin
          cnt_n   = '0;
          state_n = (WARMUP == 0) ? S_READY : S_MIX;
        end
      end
      S_MIX: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == MIX_LAST) begin
          cnt_n   = '0;
          state_n = S_READY;
        end
      end
      S_READY: begin
        if (accept_word) begin
          data_n  = bus.in_data;
          cnt_n   = '0;
          state_n = S_GEN;
        end
      end
      S_GEN: begin
        // First keystream bit ends up in bit 0 after DATA_W right shifts.
        ks_word_n             = ks_word >> 1;
        ks_word_n[DATA_W-1]   = ks;
        cnt_n                 = cnt + CNT_W'(1);
        if (cnt == GEN_LAST) begin
          out_data_n  = data_q ^ ks_word_n;
          out_valid_n = 1'b1;
          cnt_n       = '0;
          state_n     = S_READY;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (start_ok) begin
      state_n = S_KEY;
      cnt_n   = '0;
      frame_n = bus.frame;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1          <= '0;
      r2          <= '0;
      r3          <= '0;
      cnt         <= '0;
      frame_q     <= '0;
      data_q      <= '0;
      ks_word     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      r1          <= r1_n;
      r2          <= r2_n;
      r3          <= r3_n;
      cnt         <= cnt_n;
      frame_q     <= frame_n;
      data_q      <= data_n;
      ks_word     <= ks_word_n;
      out_data_q  <= out_data_n;
      out_valid_q <= out_valid_n;
    end
  end

  assign bus.key_ready = (state == S_KEY);
  assign bus.in_ready  = in_ready_i;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ks_valid  = (state == S_GEN);
  assign bus.ks_bit    = (state == S_GEN) && ks;
  assign bus.busy      = (state != S_IDLE) && (state != S_READY);

endmodule

// File: tb/tb_a5_stream_cipher.sv
// Testbench for a5_stream_cipher: vector table, scoreboard, hand-written corner sequences.
// Latency: n/a.
// Backpressure: drives out_ready low to exercise output hold.
module tb_a5_stream_cipher;
  localparam int DW = 8, KW = 64, FW = 22, WU = 100;

  logic clk = 1'b0;
  logic rst;

  a5_stream_cipher_if #(.DATA_W(DW), .FRAME_W(FW)) bus ();

  a5_stream_cipher #(.DATA_W(DW), .KEY_W(KW), .FRAME_W(FW), .WARMUP(WU)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          tbl [0:28];
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] sb_exp;
  bit            ks_log [$];
  bit            gks [0:227];
  int            key_cycles = 0;
  int            busy_cycles = 0;
  logic [18:0]   m1;
  logic [21:0]   m2;
  logic [22:0]   m3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference A5/1 model in tap-mask form.
  task automatic m_clock(input bit all, input bit inj);
    bit mj, c1, c2, c3;
    mj = (int'(m1[8]) + int'(m2[10]) + int'(m3[10])) >= 2;
    c1 = all || (m1[8] == mj);
    c2 = all || (m2[10] == mj);
    c3 = all || (m3[10] == mj);
    if (c1) m1 = {m1[17:0], (^(m1 & 19'h72000)) ^ inj};
    if (c2) m2 = {m2[20:0], (^(m2 & 22'h300000)) ^ inj};
    if (c3) m3 = {m3[21:0], (^(m3 & 23'h700080)) ^ inj};
  endtask

  task automatic model_setup(input logic [63:0] key, input logic [FW-1:0] fr);
    m1 = '0; m2 = '0; m3 = '0;
    for (int i = 0; i < KW; i++) m_clock(1'b1, key[i]);
    for (int i = 0; i < FW; i++) m_clock(1'b1, fr[i]);
    for (int i = 0; i < WU; i++) m_clock(1'b0, 1'b0);
  endtask

  task automatic model_word(input logic [DW-1:0] d, output logic [DW-1:0] e);
    e = d;
    for (int i = 0; i < DW; i++) begin
      m_clock(1'b0, 1'b0);
      e[i] = e[i] ^ (m1[18] ^ m2[21] ^ m3[22]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    while (bus.busy && n < 1000) begin tick(); n++; end
    check(name, 32'(bus.busy), 0);
  endtask

  // gappy=1 puts an idle cycle (carrying a wrong bit) before every key bit.
  task automatic start_session(input logic [63:0] key, input logic [FW-1:0] fr, input bit gappy);
    bus.start = 1'b1; bus.frame = fr;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < KW; i++) begin
      if (gappy) begin bus.key_valid = 1'b0; bus.key_bit = ~key[i]; tick(); end
      bus.key_valid = 1'b1; bus.key_bit = key[i];
      tick();
    end
    bus.key_valid = 1'b0;
    model_setup(key, fr);
    wait_not_busy("session_ready");
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic [DW-1:0] e_tbl, input bit use_tbl);
    logic [DW-1:0] e;
    int n = 0;
    bus.in_data = d; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    check("in_ready_seen", 32'(bus.in_ready), 1);
    model_word(d, e);
    sb_q.push_back(use_tbl ? e_tbl : e);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    check("out_valid_seen", 32'(bus.out_valid), 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 500) begin tick(); n++; end
    check("drain", 32'(sb_q.size()), 0);
  endtask

  // Monitors and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.ks_valid)  ks_log.push_back(bus.ks_bit);
      if (bus.key_ready) key_cycles++;
      if (bus.busy)      busy_cycles++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_unexpected: got out_data %0h, expected no output", bus.out_data);
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_out_data", 32'(bus.out_data), 32'(sb_exp));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [119:0]    ga, gb;
    logic [63:0]   gkey;
    logic [7:0]    kw;
    logic [DW-1:0] held;
    int            bad, lat;

    // Published A5/1 vector (key bytes 12 23 45 67 89 AB CD EF, frame 0x134),
    // bits packed MSB first per byte.
    ga = 120'h534EAA582FE8151AB6E1855A728C00;
    gb = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    for (int i = 0; i < 114; i++) begin
      gks[i]       = ga[119-i];
      gks[114 + i] = gb[119-i];
    end
    tbl[0] = '{din: 8'hA5, exp: 8'hA5};
    for (int w = 0; w < 28; w++) begin
      for (int b = 0; b < 8; b++) kw[b] = gks[8*w + b];
      tbl[w+1] = '{din: w[7:0], exp: w[7:0] ^ kw};
    end
    // Serial order: byte 0x12 first, each byte LSB first.
    gkey = 64'hEFCDAB8967452312;

    rst = 1'b1;
    bus.start = 1'b0; bus.frame = '0; bus.key_bit = 1'b0; bus.key_valid = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_key_ready", 32'(bus.key_ready), 0);
    check("rst_in_ready",  32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data), 0);
    check("rst_ks_bit",    32'(bus.ks_bit), 0);
    check("rst_ks_valid",  32'(bus.ks_valid), 0);
    check("rst_busy",      32'(bus.busy), 0);
    rst = 1'b0;
    tick();

    // Reset after 30 key bits abandons the session.
    bus.start = 1'b1; bus.frame = 22'h3;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin bus.key_valid = 1'b1; bus.key_bit = i[0]; tick(); end
    check("midkey_key_ready", 32'(bus.key_ready), 1);
    rst = 1'b1;
    #1;
    check("midkey_rst_key_ready", 32'(bus.key_ready), 0);
    check("midkey_rst_busy",      32'(bus.busy), 0);
    tick();
    check("midkey_rst_out_valid", 32'(bus.out_valid), 0);
    rst = 1'b0; bus.key_valid = 1'b0;
    tick();
    check("midkey_idle_busy", 32'(bus.busy), 0);

    // All-zero key and frame; the full 64 bits are needed again.
    bus.start = 1'b1; bus.frame = '0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < KW; i++) begin
      if (i == KW - 1) check("zero_key_63", 32'(bus.key_ready), 1);
      bus.key_valid = 1'b1; bus.key_bit = 1'b0;
      tick();
    end
    bus.key_valid = 1'b0;
    check("zero_key_64", 32'(bus.key_ready), 0);
    model_setup(64'h0, '0);
    wait_not_busy("zero_ready");
    ks_log.delete();
    send_word(tbl[0].din, tbl[0].exp, 1'b1);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin tick(); lat++; end
    check("zero_latency", 32'(lat), 32'(DW + 1));
    drain();
    check("zero_ks_count", 32'(ks_log.size()), 32'(DW));
    bad = 0;
    foreach (ks_log[i]) if (ks_log[i] != 1'b0) bad++;
    check("zero_ks_ones", 32'(bad), 0);

    // Golden session: table words plus one more to cover 228 keystream bits.
    start_session(gkey, 22'h134, 1'b0);
    ks_log.delete();
    for (int w = 1; w <= 28; w++) send_word(tbl[w].din, tbl[w].exp, 1'b1);
    send_word(8'h1C, 8'h00, 1'b0);
    drain();
    check("gold_ks_count", 32'(ks_log.size()), 232);
    bad = 0;
    for (int i = 0; i < 228 && i < ks_log.size(); i++) if (ks_log[i] != gks[i]) bad++;
    check("gold_ks_bits", 32'(bad), 0);

    // key_valid alternating 0/1: KEY lasts 128 cycles, same keystream.
    key_cycles = 0;
    start_session(gkey, 22'h134, 1'b1);
    check("gappy_key_cycles", 32'(key_cycles), 128);
    ks_log.delete();
    for (int w = 1; w <= 4; w++) send_word(tbl[w].din, tbl[w].exp, 1'b1);
    drain();
    bad = 0;
    for (int i = 0; i < 32 && i < ks_log.size(); i++) if (ks_log[i] != gks[i]) bad++;
    check("gappy_ks_bits", 32'(bad), 0);

    // Output hold for 20 cycles; second word accepted as out_ready rises.
    bus.out_ready = 1'b0;
    send_word(8'h3C, 8'h00, 1'b0);
    wait_out_valid();
    held = bus.out_data;
    bus.in_data = 8'hC3; bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.out_valid || bus.out_data !== held || bus.in_ready) bad++;
      tick();
    end
    check("hold_stable", 32'(bad), 0);
    bus.out_ready = 1'b1;
    #1;
    check("hold_release_in_ready", 32'(bus.in_ready), 1);
    model_word(8'hC3, sb_exp);
    sb_q.push_back(sb_exp);
    tick();
    bus.in_valid = 1'b0;
    check("hold_second_busy", 32'(bus.busy), 1);
    check("hold_out_cleared", 32'(bus.out_valid), 0);
    drain();

    // start during GEN is ignored; keystream continues.
    send_word(8'h77, 8'h00, 1'b0);
    bus.start = 1'b1; bus.frame = 22'h155;
    tick();
    bus.start = 1'b0;
    check("start_gen_key_ready", 32'(bus.key_ready), 0);
    check("start_gen_busy", 32'(bus.busy), 1);
    drain();

    // start in READY with a pending result is ignored.
    bus.out_ready = 1'b0;
    send_word(8'h88, 8'h00, 1'b0);
    wait_out_valid();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_ready_ov_key_ready", 32'(bus.key_ready), 0);
    check("start_ready_ov_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    drain();

    // Rekey from READY with out_valid=0: busy for KEY+FRAME+WARMUP cycles.
    busy_cycles = 0;
    start_session(gkey, 22'h2A5, 1'b0);
    check("rekey_busy_cycles", 32'(busy_cycles), 32'(KW + FW + WU));
    send_word(8'h5A, 8'h00, 1'b0);
    send_word(8'hFF, 8'h00, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/a5_stream_cipher.md
Name: a5_stream_cipher

Overview:
- Parametrised A5/1 stream-cipher engine that encrypts (or decrypts) a word stream.
- Loads a 64-bit session key serially and a 22-bit frame number in parallel, then runs the standard key/frame mixing and a warm-up discard phase.
- After warm-up, XORs each accepted DATA_W-bit word with fresh keystream bits.
- Sits between the hardware key source and the payload datapath, with valid/ready on both data sides.

Parameters:
- DATA_W, 8, payload word width in bits (1..32); one keystream bit is produced per cycle, so each word takes DATA_W cycles.
- KEY_W, 64, serial key length in bits.
- FRAME_W, 22, frame-number length in bits.
- WARMUP, 100, majority-clocked cycles whose keystream is discarded before payload use (0 is allowed).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; latches frame and begins a new key session
- frame  in  FRAME_W  frame number, sampled when start is accepted
- key_bit  in  1  serial key bit, LSB first
- key_valid  in  1  key_bit is valid this cycle
- key_ready  out  1  high while the block is in state KEY
- in_data  in  DATA_W  plaintext word
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts a word this cycle
- out_data  out  DATA_W  in_data XOR keystream word
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- ks_bit  out  1  keystream bit of the current cycle (debug)
- ks_valid  out  1  ks_bit is meaningful (GEN cycles only)
- busy  out  1  state is not IDLE or READY

Behaviour:
- Reset: asynchronous, takes effect immediately; state goes to IDLE. All outputs are 0; R1/R2/R3, counters and data registers are 0. Reset mid-session abandons the session with no partial output.
- Registers (bit 0 = input end):
  - R1[18:0]: feedback R1[13]^R1[16]^R1[17]^R1[18]; clock bit R1[8].
  - R2[21:0]: feedback R2[20]^R2[21]; clock bit R2[10].
  - R3[22:0]: feedback R3[7]^R3[20]^R3[21]^R3[22]; clock bit R3[10].
  - Shift is toward the MSB; the new bit enters bit 0.
- Majority: m = maj(R1[8],R2[10],R3[10]). A register steps only if its clock bit equals m.
- Keystream: ks = R1[18]^R2[21]^R3[22], computed after the step.
- IDLE:
  - start -> KEY. Clears R1/R2/R3 and the counter; latches frame.
- KEY:
  - Each cycle with key_valid, all three registers step unconditionally, with key_bit XORed into each feedback bit.
  - Cycles without key_valid stall; no step occurs.
  - After KEY_W accepted bits -> FRAME.
- FRAME:
  - FRAME_W cycles, unconditional stepping, with frame bit i (LSB first) XORed into feedback.
  - Then -> MIX, or -> READY if WARMUP=0.
- MIX:
  - WARMUP cycles of majority stepping; keystream discarded; ks_valid=0.
  - Then -> READY.
- READY:
  - in_ready = !out_valid || out_ready.
  - On in_valid && in_ready: latch in_data, clear the bit index, -> GEN.
  - start with !out_valid -> KEY (rekey; frame re-latched).
  - start while out_valid=1 is ignored.
- GEN:
  - DATA_W cycles of majority stepping; ks_valid=1 each cycle.
  - Bit index i receives ks (first bit -> bit 0).
  - On the edge ending the last GEN cycle: out_data = data ^ ks_word, out_valid=1, -> READY.
  - start is ignored in GEN.
- Latency: a word accepted in cycle T has out_valid visible from cycle T+DATA_W+1. Throughput is one word per DATA_W+1 cycles.
- Output hold: out_valid stays high and out_data stays stable until out_ready. out_valid clears on the handshake unless a new word completes in the same edge; by construction it cannot.
- start outside IDLE/READY is ignored. key_valid outside KEY is ignored. in_valid is ignored unless in_ready.
- Keystream continuity: keystream is continuous across words; there is no re-mixing between words of one session.

Test Plan:
- Reset mid-KEY (after 30 key bits) -> all outputs 0 next cycle, state IDLE. The next start requires the full 64 key bits again.
- Key all 0, frame 0 -> registers stay 0; in_data 0xA5 -> out_data 0xA5 after 9 cycles; ks_bit 0 throughout GEN.
- Key 0x1223456789ABCDEF, frame 0x134, WARMUP=100 -> first 228 ks bits match the golden C A5/1 model bit-for-bit. Also check out_data for words 0x00..0x1B.
- key_valid toggled 1/0 every other cycle -> KEY lasts 128 cycles; keystream identical to the contiguous-key run.
- out_ready held 0 for 20 cycles after the first word -> out_valid and out_data stable, in_ready 0. The second word is accepted in the cycle out_ready rises.
- start asserted in GEN and in READY with out_valid=1 -> ignored. start in READY with out_valid=0 -> rekey; busy=1 for 64+22+WARMUP cycles (minimum).
